// File: rtl/tlul_reg_responder.sv
// tlul_reg_responder: TL-UL device port bridging single requests to a simple register strobe interface
module tlul_reg_responder #(
  parameter int          SrcW          = 8,
  parameter logic [31:0] AddrSpace     = 32'h40090000,
  parameter logic [31:0] AddrMask      = 32'h0000ffff,
  parameter int          TimeoutCycles = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            a_valid_i,
  input  logic [2:0]      a_opcode_i,
  input  logic [1:0]      a_size_i,
  input  logic [SrcW-1:0] a_source_i,
  input  logic [31:0]     a_address_i,
  input  logic [3:0]      a_mask_i,
  input  logic [31:0]     a_data_i,
  output logic            a_ready_o,
  output logic            d_valid_o,
  output logic [2:0]      d_opcode_o,
  output logic [1:0]      d_size_o,
  output logic [SrcW-1:0] d_source_o,
  output logic [31:0]     d_data_o,
  output logic            d_error_o,
  input  logic            d_ready_i,
  output logic            re_o,
  output logic            we_o,
  output logic [31:0]     addr_o,
  output logic [31:0]     wdata_o,
  output logic [3:0]      be_o,
  input  logic [31:0]     rdata_i,
  input  logic            rerror_i,
  input  logic            rready_i
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [7:0] CntMax = 8'(TimeoutCycles - 1);

  logic [1:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            get_q, get_d;
  logic            err_q, err_d;
  logic [1:0]      size_q, size_d;
  logic [SrcW-1:0] src_q, src_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      lanes;
  logic            req_err;

  // byte lanes naturally covered by the request size/offset, and request legality
  always_comb begin
    lanes = a_size_i == 2'd0 ? 4'b0001 << a_address_i[1:0] :
            a_size_i == 2'd1 ? (a_address_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    req_err = !(a_opcode_i == 3'd0 || a_opcode_i == 3'd1 || a_opcode_i == 3'd4) ||
              a_size_i == 2'd3 ||
              (a_size_i == 2'd1 && a_address_i[0]) ||
              (a_size_i == 2'd2 && a_address_i[1:0] != 2'd0) ||
              ((a_address_i & ~AddrMask) != AddrSpace) ||
              (a_opcode_i == 3'd0 && (a_mask_i & lanes) != lanes) ||
              ((a_mask_i & ~lanes) != 4'd0);
  end

  // transaction sequencing: accept, wait for register completion or timeout, hold response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    get_d   = get_q;
    err_d   = err_q;
    size_d  = size_q;
    src_d   = src_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    mask_d  = mask_q;
    if (state_q == IDLE && a_valid_i) begin
      state_d = req_err ? RESP : ACCESS;
      cnt_d   = 8'd0;
      get_d   = a_opcode_i == 3'd4;
      err_d   = req_err;
      size_d  = a_size_i;
      src_d   = a_source_i;
      addr_d  = a_address_i & AddrMask & ~32'h3;
      wdata_d = a_data_i;
      mask_d  = a_mask_i;
      data_d  = (req_err && a_opcode_i == 3'd4) ? 32'hFFFFFFFF : 32'd0;
    end else if (state_q == ACCESS) begin
      if (rready_i) begin
        state_d = RESP;
        err_d   = rerror_i;
        data_d  = get_q ? (rerror_i ? 32'hFFFFFFFF : rdata_i) : 32'd0;
      end else if (cnt_q == CntMax) begin
        state_d = RESP;
        err_d   = 1'b1;
        data_d  = get_q ? 32'hFFFFFFFF : 32'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (state_q == RESP && d_ready_i) begin
      state_d = IDLE;
    end
  end

  // state registers, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      get_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      src_q   <= '0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      get_q   <= get_d;
      err_q   <= err_d;
      size_q  <= size_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign a_ready_o  = state_q == IDLE;
  assign d_valid_o  = state_q == RESP;
  assign d_opcode_o = {2'b00, get_q};
  assign d_size_o   = size_q;
  assign d_source_o = src_q;
  assign d_data_o   = data_q;
  assign d_error_o  = err_q;
  assign re_o       = state_q == ACCESS && get_q;
  assign we_o       = state_q == ACCESS && !get_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign be_o       = state_q == ACCESS ? (get_q ? 4'hF : mask_q) : 4'h0;
endmodule

// File: tb/tb_tlul_reg_responder.sv
// tb_tlul_reg_responder: directed vector table plus multi-cycle corner sequences
module tb_tlul_reg_responder;
  logic        clk = 0;
  logic        rst;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_ready;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic [31:0] d_data;
  logic        d_error;
  logic        d_ready;
  logic        re, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        rerror, rready;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  tlul_reg_responder #(.TimeoutCycles(4)) dut (
    .clk_i(clk), .rst_i(rst), .a_valid_i(a_valid), .a_opcode_i(a_opcode), .a_size_i(a_size),
    .a_source_i(a_source), .a_address_i(a_address), .a_mask_i(a_mask), .a_data_i(a_data),
    .a_ready_o(a_ready), .d_valid_o(d_valid), .d_opcode_o(d_opcode), .d_size_o(d_size),
    .d_source_o(d_source), .d_data_o(d_data), .d_error_o(d_error), .d_ready_i(d_ready),
    .re_o(re), .we_o(we), .addr_o(addr), .wdata_o(wdata), .be_o(be),
    .rdata_i(rdata), .rerror_i(rerror), .rready_i(rready)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [31:0] adr;
    logic [3:0]  msk;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        rerr;
    logic        acc;
    logic [3:0]  ebe;
    logic [31:0] eadr;
    logic        eop;
    logic [31:0] edata;
    logic        eerr;
    logic        chkd;
  } vec_t;

  vec_t v[12];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s got %h expected %h", n, act, exp);
    else passed++;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] adr,
                      input logic [3:0] msk, input logic [31:0] wd, input logic [7:0] src);
    a_valid = 1; a_opcode = op; a_size = sz; a_address = adr; a_mask = msk; a_data = wd; a_source = src;
  endtask

  initial begin
    logic ok;
    int n;
    rst = 1; a_valid = 0; a_opcode = 0; a_size = 0; a_source = 0; a_address = 0; a_mask = 0;
    a_data = 0; d_ready = 0; rdata = 0; rerror = 0; rready = 0;
    v[0]  = '{3'd4, 2'd2, 32'h40090004, 4'hF, 32'h0, 32'hA5A51234, 1'b0, 1'b1, 4'hF, 32'h4, 1'b1, 32'hA5A51234, 1'b0, 1'b1};
    v[1]  = '{3'd1, 2'd1, 32'h40090002, 4'hC, 32'h12340000, 32'h0, 1'b0, 1'b1, 4'hC, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
    v[2]  = '{3'd4, 2'd2, 32'h400A0000, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1};
    v[3]  = '{3'd4, 2'd2, 32'h40090001, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1};
    v[4]  = '{3'd0, 2'd2, 32'h40090008, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 4'hF, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1};
    v[5]  = '{3'd0, 2'd1, 32'h40090002, 4'h4, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
    v[6]  = '{3'd2, 2'd2, 32'h40090000, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
    v[7]  = '{3'd4, 2'd3, 32'h40090000, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1};
    v[8]  = '{3'd1, 2'd0, 32'h40090003, 4'h1, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
    v[9]  = '{3'd1, 2'd0, 32'h40090003, 4'h8, 32'h77000000, 32'h0, 1'b0, 1'b1, 4'h8, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
    v[10] = '{3'd4, 2'd2, 32'h4009FFFC, 4'hF, 32'h0, 32'h13579BDF, 1'b0, 1'b1, 4'hF, 32'hFFFC, 1'b1, 32'h13579BDF, 1'b0, 1'b1};
    v[11] = '{3'd4, 2'd2, 32'h40090010, 4'hF, 32'h0, 32'h00000001, 1'b1, 1'b1, 4'hF, 32'h10, 1'b1, 32'h0, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset_a_ready", a_ready, 1);
    chk("reset_d_valid", d_valid, 0);
    chk("reset_strobes", {re, we}, 0);
    chk("reset_data", d_data, 0);
    rst = 0;
    @(negedge clk);
    chk("post_reset_a_ready", a_ready, 1);
    for (int i = 0; i < 12; i++) begin
      send(v[i].op, v[i].sz, v[i].adr, v[i].msk, v[i].wd, 8'(i + 16));
      chk($sformatf("v%0d_a_ready", i), a_ready, 1);
      @(negedge clk);
      a_valid = 0;
      if (v[i].acc) begin
        chk($sformatf("v%0d_re", i), re, v[i].op == 3'd4);
        chk($sformatf("v%0d_we", i), we, v[i].op != 3'd4);
        chk($sformatf("v%0d_be", i), be, v[i].ebe);
        chk($sformatf("v%0d_addr", i), addr, v[i].eadr);
        if (v[i].op != 3'd4) chk($sformatf("v%0d_wdata", i), wdata, v[i].wd);
        chk($sformatf("v%0d_early_dvalid", i), d_valid, 0);
        chk($sformatf("v%0d_busy_a_ready", i), a_ready, 0);
        rready = 1; rdata = v[i].rd; rerror = v[i].rerr;
        @(negedge clk);
        rready = 0; rerror = 0;
      end else begin
        chk($sformatf("v%0d_no_strobe", i), {re, we}, 0);
      end
      chk($sformatf("v%0d_d_valid", i), d_valid, 1);
      chk($sformatf("v%0d_d_opcode", i), d_opcode, {2'b0, v[i].eop});
      chk($sformatf("v%0d_d_error", i), d_error, v[i].eerr);
      chk($sformatf("v%0d_d_source", i), d_source, i + 16);
      chk($sformatf("v%0d_d_size", i), d_size, v[i].sz);
      if (v[i].chkd) chk($sformatf("v%0d_d_data", i), d_data, v[i].edata);
      d_ready = 1;
      @(negedge clk);
      d_ready = 0;
      chk($sformatf("v%0d_done_dvalid", i), d_valid, 0);
      chk($sformatf("v%0d_done_a_ready", i), a_ready, 1);
    end
    send(3'd4, 2'd2, 32'h40090020, 4'hF, 32'h0, 8'h55);
    @(negedge clk);
    a_valid = 0;
    n = 0;
    for (int c = 0; c < 20 && !d_valid; c++) begin
      if (re) n++;
      @(negedge clk);
    end
    chk("timeout_re_cycles", n, 4);
    chk("timeout_d_valid", d_valid, 1);
    chk("timeout_re_dropped", re, 0);
    chk("timeout_d_error", d_error, 1);
    chk("timeout_d_data", d_data, 32'hFFFFFFFF);
    d_ready = 1;
    @(negedge clk);
    d_ready = 0;
    send(3'd4, 2'd2, 32'h40090024, 4'hF, 32'h0, 8'h66);
    @(negedge clk);
    rready = 1; rdata = 32'h0BADF00D;
    @(negedge clk);
    rready = 0;
    send(3'd0, 2'd2, 32'h40090000, 4'hF, 32'h11111111, 8'h77);
    ok = 1;
    for (int c = 0; c < 10; c++) begin
      if (!(d_valid === 1 && a_ready === 0 && d_data === 32'h0BADF00D && d_source === 8'h66 &&
            d_opcode === 3'd1 && d_error === 0 && re === 0 && we === 0)) ok = 0;
      @(negedge clk);
    end
    chk("backpressure_stable", ok, 1);
    a_valid = 0;
    d_ready = 1;
    @(negedge clk);
    d_ready = 0;
    send(3'd4, 2'd2, 32'h40000000, 4'hF, 32'h0, 8'h01);
    @(negedge clk);
    a_valid = 0;
    chk("fast_err_d_valid", d_valid, 1);
    d_ready = 1;
    send(3'd4, 2'd2, 32'h40090028, 4'hF, 32'h0, 8'h02);
    @(negedge clk);
    d_ready = 0;
    chk("same_cycle_not_accepted", {re, a_ready}, 2'b01);
    @(negedge clk);
    a_valid = 0;
    chk("accepted_next_cycle", re, 1);
    chk("accepted_next_addr", addr, 32'h28);
    rready = 1; rdata = 32'h0;
    @(negedge clk);
    rready = 0;
    chk("late_accept_resp_src", d_source, 8'h02);
    d_ready = 1;
    @(negedge clk);
    d_ready = 0;
    send(3'd4, 2'd2, 32'h4009002C, 4'hF, 32'h0, 8'h03);
    @(negedge clk);
    a_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_reset_idle", {a_ready, d_valid, re, we}, 4'b1000);
    ok = 1;
    for (int c = 0; c < 8; c++) begin
      if (d_valid !== 0 || re !== 0) ok = 0;
      @(negedge clk);
    end
    chk("mid_reset_no_resp", ok, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
